berger_scrub_memory: RTL and testbench
======================================

Name: berger_scrub_memory

Overview:
- Parametrised Berger-coded memory: DATA_W data bits plus a zero-count check field, DEPTH words.
- Registered read port with unidirectional fault injection on the read path.
- Adds a background scrubber FSM that sweeps every word and checks its code, a saturating error counter and first-error address capture.
- Next-generation replacement for the fixed 8-bit/16-word Berger test memory; used as the Berger leg of protection-code comparisons.

Parameters:
- DATA_W, 8, data bits per word.
- ADDR_W, 4, address bits; DEPTH = 2**ADDR_W.
- ERR_CNT_W, 8, width of the saturating error counter.
- Derived: CHK_W = clog2(DATA_W+1); CODE_W = DATA_W+CHK_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-low.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_valid  out  1  read data valid.
- rd_data  out  DATA_W  read data (data field of the possibly-corrupted codeword).
- rd_error  out  1  Berger mismatch on this read.
- fault_mask  in  CODE_W  bits to corrupt.
- fault_enable  in  1  fault injection on.
- fault_zero_to_one  in  1  1: code|mask; 0: code&~mask.
- scrub_start  in  1  start one full sweep.
- scrub_busy  out  1  sweep in progress.
- scrub_done  out  1  one-cycle pulse at end of sweep.
- err_clear  in  1  clear err_count, err_flag and first_err_addr.
- err_count  out  ERR_CNT_W  saturating count of detected errors.
- err_flag  out  1  sticky: at least one error since clear.
- first_err_addr  out  ADDR_W  address of first error since clear.

Behaviour:
- Codeword layout is {data, check}. check = number of zero bits in data.
- Reset (rst=0 at clk edge):
  - Every word is set to the valid encoding of all-zero data (check = DATA_W).
  - All outputs go to 0; FSM returns to IDLE.
  - Reset mid-sweep aborts the sweep; no scrub_done pulse is issued.
- Write: wr_en stores the encoded wr_data at the edge.
- Read:
  - rd_en at cycle N gives rd_valid=1 at N+1, with rd_data and rd_error.
  - rd_error = check field != zero-count of the data field, computed after fault injection.
  - If wr_en and rd_en target the same address in the same cycle, the read returns the old word.
- Fault injection applies to user reads and scrub reads alike. It is combinational on the array output and never alters stored words.
- Scrub FSM states: IDLE, READ, CHECK, DONE.
  - IDLE: scrub_start=1 sets scrub_addr=0 and moves to READ. scrub_busy=1 in every state except IDLE.
  - READ: if wr_en|rd_en this cycle, stall in READ (user access has priority). Otherwise read scrub_addr and move to CHECK.
  - CHECK: evaluate the registered codeword.
    - If the sweep is at DEPTH-1, go to DONE.
    - Otherwise increment scrub_addr and go to READ.
  - DONE: scrub_done=1 for one cycle, then IDLE.
  - scrub_start while busy is ignored.
- Error logging: a detected error (user rd_error or scrub CHECK mismatch) does the following.
  - err_count increments, saturating at all-ones.
  - err_flag sets.
  - If err_flag was 0, first_err_addr captures the address.
  - A user error and a scrub error cannot occur in the same cycle, because of the READ stall.
  - err_clear wins over a same-cycle increment.
- Minimum sweep length with no stalls is 2*DEPTH+1 cycles from scrub_start to scrub_done.

Optional Feature:
- Macro: BERGER_FAULT_INJECT_EN.
- Defined: fault injection behaves as described above.
- Undefined: the injector is not compiled. fault_mask, fault_enable and fault_zero_to_one remain as ports but are ignored, and reads return stored codewords unaltered.

Decomposition:
- Package berger_pkg holds:
  - the clog2-based CHK_W function;
  - the zero-count function;
  - the scrub FSM state enum.
- Sub-module berger_check: combinational block taking a CODE_W codeword and producing data and mismatch. It is instantiated once and muxed between user and scrub read results.

Test Plan:
- Reset, then read all 16 addresses (defaults): rd_data=0x00, rd_error=0; err_count=0.
- Write 0xA5 to addr 3, read addr 3 with fault_enable=0: rd_valid one cycle after rd_en, rd_data=0xA5, rd_error=0.
- Read addr 3 with fault_enable=1, fault_zero_to_one=1, mask=0x001: rd_error=1; err_count=1; first_err_addr=3.
- Full scrub with fault_zero_to_one=0, mask=0x800 (MSB data bit), every word 0xFF: scrub_done after 33 cycles; err_count=16; first_err_addr=0.
- Scrub while issuing rd_en every other cycle: the sweep stalls and completes later; scrub_done fires exactly once, with no missed or duplicate addresses.
- ERR_CNT_W=2 with five injected errors: err_count holds at 3. err_clear in the same cycle as an error gives err_count=0 and err_flag=0.

Source files
------------

// File: rtl/berger_pkg.sv
// Shared definitions for the Berger-coded scrub memory.
// Contents: check-field width helper, zero-count function, scrub FSM state enum.
// Latency: n/a (package). Backpressure: n/a.
package berger_pkg;

    // Width of a Berger check field able to hold any zero count of data_w bits.
    function automatic int chk_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Number of zero bits among the low w bits of d (supports words up to 64 bits).
    function automatic int unsigned zero_count(input logic [63:0] d, input int w);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < w && !d[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

    typedef enum logic [1:0] {
        SCRUB_IDLE  = 2'd0,
        SCRUB_READ  = 2'd1,
        SCRUB_CHECK = 2'd2,
        SCRUB_DONE  = 2'd3
    } scrub_state_e;

endpackage

// File: rtl/berger_check.sv
// Berger codeword checker: splits {data, check} and flags a zero-count mismatch.
// Latency: combinational. Backpressure: none.
// Ports: code_i (codeword in), data_o (data field), mismatch_o (check != zeros(data)).
module berger_check
    import berger_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CHK_W  = chk_width(DATA_W)
) (
    input  logic [DATA_W+CHK_W-1:0] code_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    mismatch_o
);

    logic [CHK_W-1:0] zeros;

    assign data_o     = code_i[DATA_W+CHK_W-1:CHK_W];
    assign zeros      = CHK_W'(zero_count(64'(data_o), DATA_W));
    assign mismatch_o = (code_i[CHK_W-1:0] != zeros);

endmodule

// File: rtl/berger_scrub_memory.sv
// Berger-coded DEPTH x DATA_W memory with read-path fault injection, background scrubber
// and error logging. Latency: reads return 1 cycle after rd_en; sweep >= 2*DEPTH+1 cycles.
// Backpressure: none on user ports; user wr_en/rd_en stall the scrubber in READ.
// Ports: write (wr_*), read (rd_*), fault injection (fault_*), scrub control/status
// (scrub_*), error log (err_clear, err_count, err_flag, first_err_addr).
// Build option: define BERGER_FAULT_INJECT_EN to compile the read-path fault injector;
// without it the fault_* ports are ignored and stored codewords are read unaltered.
module berger_scrub_memory
    import berger_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int ERR_CNT_W = 8,
    localparam int CHK_W    = chk_width(DATA_W),
    localparam int CODE_W   = DATA_W + CHK_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_valid,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_error,
    input  logic [CODE_W-1:0]    fault_mask,
    input  logic                 fault_enable,
    input  logic                 fault_zero_to_one,
    input  logic                 scrub_start,
    output logic                 scrub_busy,
    output logic                 scrub_done,
    input  logic                 err_clear,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_flag,
    output logic [ADDR_W-1:0]    first_err_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    // All-zero data has DATA_W zero bits, so this is its valid encoding.
    localparam logic [CODE_W-1:0] RESET_WORD = {{DATA_W{1'b0}}, CHK_W'(DATA_W)};

    logic [CODE_W-1:0]    mem_q [DEPTH];
    logic [CHK_W-1:0]     wr_chk;

    // One read register is shared by user and scrub reads; the READ stall guarantees
    // they never collide.
    logic [CODE_W-1:0]    rd_code_q;
    logic                 rd_vld_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [CODE_W-1:0]    chk_code;
    logic [DATA_W-1:0]    chk_data;
    logic                 chk_mismatch;

    scrub_state_e         state_q;
    logic [ADDR_W-1:0]    scrub_addr_q;
    logic                 scrub_busy_q;
    logic                 scrub_done_q;
    logic                 user_acc;
    logic                 scrub_rd;

    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_flag_q, err_flag_d;
    logic [ADDR_W-1:0]    first_err_q, first_err_d;
    logic                 user_err;
    logic                 scrub_err;
    logic [ADDR_W-1:0]    err_addr;

    assign wr_chk   = CHK_W'(zero_count(64'(wr_data), DATA_W));
    assign user_acc = wr_en | rd_en;
    assign scrub_rd = (state_q == SCRUB_READ) && !user_acc;

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_WORD;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= {wr_data, wr_chk};
        end
    end

    // ---------------- read register ----------------
    // Reads sample the array before a same-cycle write lands, so they return the old word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_code_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_vld_q <= rd_en;
            if (rd_en) begin
                rd_code_q <= mem_q[rd_addr];
                rd_addr_q <= rd_addr;
            end else if (scrub_rd) begin
                rd_code_q <= mem_q[scrub_addr_q];
            end
        end
    end

    // ---------------- fault injection (read path only, storage untouched) ----------------
`ifdef BERGER_FAULT_INJECT_EN
    always_comb begin
        chk_code = rd_code_q;
        if (fault_enable) begin
            chk_code = fault_zero_to_one ? (rd_code_q | fault_mask) : (rd_code_q & ~fault_mask);
        end
    end
`else
    logic unused_fault;
    assign unused_fault = ^{fault_mask, fault_enable, fault_zero_to_one};
    assign chk_code     = rd_code_q;
`endif

    berger_check #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_check (
        .code_i     (chk_code),
        .data_o     (chk_data),
        .mismatch_o (chk_mismatch)
    );

    // The register also carries scrub words, so user-facing outputs are gated by rd_vld_q.
    assign rd_valid = rd_vld_q;
    assign rd_data  = rd_vld_q ? chk_data : '0;
    assign rd_error = rd_vld_q & chk_mismatch;

    // ---------------- scrub FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= SCRUB_IDLE;
            scrub_addr_q <= '0;
            scrub_busy_q <= 1'b0;
            scrub_done_q <= 1'b0;
        end else begin
            scrub_done_q <= 1'b0;
            case (state_q)
                SCRUB_IDLE: begin
                    if (scrub_start) begin
                        scrub_addr_q <= '0;
                        scrub_busy_q <= 1'b1;
                        state_q      <= SCRUB_READ;
                    end
                end
                SCRUB_READ: begin
                    if (!user_acc) begin
                        state_q <= SCRUB_CHECK;
                    end
                end
                SCRUB_CHECK: begin
                    if (scrub_addr_q == '1) begin
                        scrub_done_q <= 1'b1;
                        state_q      <= SCRUB_DONE;
                    end else begin
                        scrub_addr_q <= scrub_addr_q + 1'b1;
                        state_q      <= SCRUB_READ;
                    end
                end
                SCRUB_DONE: begin
                    scrub_busy_q <= 1'b0;
                    state_q      <= SCRUB_IDLE;
                end
                default: begin
                    scrub_busy_q <= 1'b0;
                    state_q      <= SCRUB_IDLE;
                end
            endcase
        end
    end

    assign scrub_busy = scrub_busy_q;
    assign scrub_done = scrub_done_q;

    // ---------------- error log ----------------
    // In CHECK the read register holds the scrub word (no user read preceded it).
    assign user_err  = rd_vld_q & chk_mismatch;
    assign scrub_err = (state_q == SCRUB_CHECK) & chk_mismatch;
    assign err_addr  = user_err ? rd_addr_q : scrub_addr_q;

    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        first_err_d = first_err_q;
        if (err_clear) begin
            err_cnt_d   = '0;
            err_flag_d  = 1'b0;
            first_err_d = '0;
        end else if (user_err || scrub_err) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            err_flag_d = 1'b1;
            if (!err_flag_q) begin
                first_err_d = err_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_count      = err_cnt_q;
    assign err_flag       = err_flag_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_berger_scrub_memory.sv
// Directed bench for berger_scrub_memory (default 8-bit/16-word) plus a 2-bit-counter copy.
// Expectations depend on whether BERGER_FAULT_INJECT_EN is defined for this build.
module tb_berger_scrub_memory;

`ifdef BERGER_FAULT_INJECT_EN
    localparam bit FI = 1'b1;
`else
    localparam bit FI = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [11:0] fault_mask;
    logic        fault_enable;
    logic        fault_zero_to_one;
    logic        scrub_start;
    logic        err_clear;

    logic        rd_valid, rd_error, scrub_busy, scrub_done, err_flag;
    logic [7:0]  rd_data, err_count;
    logic [3:0]  first_err_addr;

    logic        unused_b_rd_valid, unused_b_rd_error, unused_b_busy, unused_b_done;
    logic [7:0]  unused_b_rd_data;
    logic [3:0]  unused_b_first;
    logic [1:0]  b_err_count;
    logic        b_err_flag;

    int checks = 0;
    int errors = 0;

    berger_scrub_memory dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_error(rd_error), .fault_mask(fault_mask), .fault_enable(fault_enable),
        .fault_zero_to_one(fault_zero_to_one), .scrub_start(scrub_start),
        .scrub_busy(scrub_busy), .scrub_done(scrub_done), .err_clear(err_clear),
        .err_count(err_count), .err_flag(err_flag), .first_err_addr(first_err_addr)
    );

    berger_scrub_memory #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(unused_b_rd_valid), .rd_data(unused_b_rd_data),
        .rd_error(unused_b_rd_error), .fault_mask(fault_mask), .fault_enable(fault_enable),
        .fault_zero_to_one(fault_zero_to_one), .scrub_start(scrub_start),
        .scrub_busy(unused_b_busy), .scrub_done(unused_b_done), .err_clear(err_clear),
        .err_count(b_err_count), .err_flag(b_err_flag), .first_err_addr(unused_b_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Leaves the bench in the rd_valid cycle of the issued read.
    task automatic rd_issue(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic clr();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ndone;
        int done_at;

        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        fault_mask = '0; fault_enable = 1'b0; fault_zero_to_one = 1'b0;
        scrub_start = 1'b0; err_clear = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // Reset state
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_err", rd_error, 0);
        check_eq("rst_busy", scrub_busy, 0);
        check_eq("rst_cnt", err_count, 0);
        check_eq("rst_flag", err_flag, 0);
        check_eq("rst_first", first_err_addr, 0);

        // Every word reads back as valid all-zero data
        for (int i = 0; i < 16; i++) begin
            rd_issue(i[3:0]);
            check_eq($sformatf("init_data%0d", i), rd_data, 8'h00);
            check_eq($sformatf("init_err%0d", i), rd_error, 0);
        end
        tick();
        check_eq("init_cnt", err_count, 0);

        // Write/read with one-cycle latency
        wr(4'd3, 8'hA5);
        rd_en = 1'b1; rd_addr = 4'd3;
        check_eq("a5_pre_valid", rd_valid, 0);
        tick();
        rd_en = 1'b0;
        check_eq("a5_valid", rd_valid, 1);
        check_eq("a5_data", rd_data, 8'hA5);
        check_eq("a5_err", rd_error, 0);
        tick();
        check_eq("a5_valid_drop", rd_valid, 0);

        // Check bit 0 forced high: check field 4 -> 5, data untouched
        fault_enable = 1'b1; fault_zero_to_one = 1'b1; fault_mask = 12'h001;
        rd_issue(4'd3);
        check_eq("inj_data", rd_data, 8'hA5);
        check_eq("inj_err", rd_error, FI ? 1 : 0);
        tick();
        fault_enable = 1'b0; fault_mask = '0;
        check_eq("inj_cnt", err_count, FI ? 1 : 0);
        check_eq("inj_flag", err_flag, FI ? 1 : 0);
        check_eq("inj_first", first_err_addr, FI ? 3 : 0);
        rd_issue(4'd3);
        check_eq("inj_stored_intact", rd_error, 0);

        // Same-cycle write and read of one address returns the old word
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("rw_old", rd_data, 8'h00);
        rd_issue(4'd5);
        check_eq("rw_new", rd_data, 8'h3C);

        clr();
        check_eq("clr_cnt", err_count, 0);
        check_eq("clr_flag", err_flag, 0);
        check_eq("clr_first", first_err_addr, 0);

        // Full sweep, all words 0xFF, data MSB forced low -> every word mismatches
        for (int i = 0; i < 16; i++) wr(i[3:0], 8'hFF);
        fault_enable = 1'b1; fault_zero_to_one = 1'b0; fault_mask = 12'h800;
        scrub_start = 1'b1;
        tick();
        scrub_start = 1'b0;
        cyc = 1;
        check_eq("sweep_busy", scrub_busy, 1);
        while (!scrub_done && cyc < 100) begin
            scrub_start = (cyc == 10);   // restart request while busy must be ignored
            tick();
            cyc++;
        end
        scrub_start = 1'b0;
        check_eq("sweep_len", cyc, 33);
        check_eq("sweep_cnt", err_count, FI ? 16 : 0);
        check_eq("sweep_first", first_err_addr, 0);
        check_eq("sweep_sat_cnt", b_err_count, FI ? 3 : 0);
        tick();
        check_eq("sweep_done_pulse", scrub_done, 0);
        check_eq("sweep_idle", scrub_busy, 0);

        // Sweep stalled by user reads of a word that stays valid under the fault
        wr(4'd15, 8'h7F);
        clr();
        scrub_start = 1'b1;
        tick();
        scrub_start = 1'b0;
        ndone = 0; done_at = 0;
        for (int c = 1; c < 150; c++) begin
            rd_en = c[0]; rd_addr = 4'd15;
            tick();
            if (scrub_done) begin
                ndone++;
                if (done_at == 0) done_at = c + 1;
            end
        end
        rd_en = 1'b0;
        tick();
        check_eq("stall_done_once", ndone, 1);
        check_eq("stall_longer", done_at > 33, 1);
        check_eq("stall_cnt", err_count, FI ? 15 : 0);
        check_eq("stall_first", first_err_addr, 0);

        // Saturation: five user-read errors on word 0 (0xFF)
        clr();
        for (int i = 0; i < 5; i++) begin
            rd_issue(4'd0);
            tick();
        end
        check_eq("sat5_cnt", err_count, FI ? 5 : 0);
        check_eq("sat5_cnt2", b_err_count, FI ? 3 : 0);
        check_eq("sat5_flag2", b_err_flag, FI ? 1 : 0);

        // err_clear beats a same-cycle error
        rd_issue(4'd0);
        err_clear = 1'b1;
        check_eq("clrwin_rderr", rd_error, FI ? 1 : 0);
        tick();
        err_clear = 1'b0;
        check_eq("clrwin_cnt", err_count, 0);
        check_eq("clrwin_flag", err_flag, 0);
        check_eq("clrwin_cnt2", b_err_count, 0);
        check_eq("clrwin_flag2", b_err_flag, 0);
        rd_issue(4'd2);
        tick();
        check_eq("after_clr_first", first_err_addr, FI ? 2 : 0);
        fault_enable = 1'b0; fault_mask = '0;

        // Reset in mid-sweep aborts without a done pulse and restores memory
        scrub_start = 1'b1;
        tick();
        scrub_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("midrst_busy", scrub_busy, 0);
        check_eq("midrst_cnt", err_count, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (scrub_done) ndone++;
        end
        check_eq("midrst_no_done", ndone, 0);
        rd_issue(4'd7);
        check_eq("midrst_mem", rd_data, 8'h00);
        check_eq("midrst_err", rd_error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
